// File: rtl/mv_pe_con.sv
// Matrix-vector processing element: loads a vector from BRAM into local RAM,
// then streams NUM_ROWS matrix rows through a 32-bit MAC and writes each dot product back.
// Optional build macro MV_PE_CON_RELU_EN clamps negative results to zero on write-back.
module mv_pe_con #(
  parameter int VECTOR_SIZE = 64,
  parameter int L_RAM_SIZE  = 6,
  parameter int NUM_ROWS    = 4,
  parameter int RD_LAT      = 2
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        start,
  output logic        done,
  output logic [31:0] BRAM_ADDR,
  output logic [31:0] BRAM_WRDATA,
  output logic [3:0]  BRAM_WE,
  output logic        BRAM_CLK,
  input  logic [31:0] BRAM_RDDATA
);

  localparam int PHASE = VECTOR_SIZE + RD_LAT;
  localparam int CW0   = $clog2(PHASE + 1);
  localparam int CW    = (CW0 > L_RAM_SIZE) ? CW0 : L_RAM_SIZE + 1;
  localparam int RW    = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_V = 3'd1,
    MAC    = 3'd2,
    WRITE  = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t              state, state_nx;
  logic [CW-1:0]       cnt, cnt_nx;
  logic [RW-1:0]       row, row_nx;
  logic [31:0]         acc, acc_nx;
  logic [31:0]         result;
  logic [31:0]         addr_nx, wrdata_nx;
  logic [3:0]          we_nx;
  logic                done_nx;
  logic                capture;
  logic [L_RAM_SIZE-1:0] ridx;
  logic [31:0]         vec_word;
  logic [31:0]         prod;
  logic [31:0]         vram [2**L_RAM_SIZE];

  assign BRAM_CLK = aclk;

  // Read data for element i arrives RD_LAT cycles after its address, so element index = cnt - RD_LAT.
  assign capture  = ((state == LOAD_V) || (state == MAC)) && (cnt >= CW'(RD_LAT));
  assign ridx     = L_RAM_SIZE'(cnt - CW'(RD_LAT));
  assign vec_word = vram[ridx];
  assign prod     = $signed(BRAM_RDDATA) * $signed(vec_word);

  // Sequencing: state, phase cycle counter and row index
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    row_nx   = row;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nx = LOAD_V;
          cnt_nx   = {CW{1'b0}};
          row_nx   = {RW{1'b0}};
        end else begin
          state_nx = state;
        end
      end
      LOAD_V: begin
        if (cnt == CW'(PHASE - 1)) begin
          state_nx = MAC;
          cnt_nx   = {CW{1'b0}};
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      MAC: begin
        if (cnt == CW'(PHASE - 1)) begin
          state_nx = WRITE;
          cnt_nx   = {CW{1'b0}};
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      WRITE: begin
        cnt_nx = {CW{1'b0}};
        if (row == RW'(NUM_ROWS - 1)) begin
          state_nx = DONE;
        end else begin
          state_nx = MAC;
          row_nx   = row + RW'(1);
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Accumulator restarts from the first product of each row
  always_comb begin
    acc_nx = acc;
    if ((state == MAC) && capture) begin
      if (cnt == CW'(RD_LAT)) begin
        acc_nx = prod;
      end else begin
        acc_nx = acc + prod;
      end
    end else begin
      acc_nx = acc;
    end
  end

  // Write-back value, optionally rectified
  always_comb begin
`ifdef MV_PE_CON_RELU_EN
    if (acc_nx[31]) begin
      result = 32'd0;
    end else begin
      result = acc_nx;
    end
`else
    result = acc_nx;
`endif
  end

  // Outputs are registered, so they are derived from the state being entered
  always_comb begin
    addr_nx   = 32'd0;
    wrdata_nx = 32'd0;
    we_nx     = 4'h0;
    done_nx   = 1'b0;
    case (state_nx)
      LOAD_V: begin
        if (cnt_nx < CW'(VECTOR_SIZE)) begin
          addr_nx = 32'(cnt_nx) << 2;
        end else begin
          addr_nx = 32'd0;
        end
      end
      MAC: begin
        if (cnt_nx < CW'(VECTOR_SIZE)) begin
          addr_nx = (32'(VECTOR_SIZE) * (32'(row_nx) + 32'd1) + 32'(cnt_nx)) << 2;
        end else begin
          addr_nx = 32'd0;
        end
      end
      WRITE: begin
        addr_nx   = (32'(VECTOR_SIZE * (NUM_ROWS + 1)) + 32'(row_nx)) << 2;
        wrdata_nx = result;
        we_nx     = 4'hF;
      end
      DONE: begin
        done_nx = 1'b1;
      end
      default: begin
        done_nx = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state       <= IDLE;
      cnt         <= {CW{1'b0}};
      row         <= {RW{1'b0}};
      acc         <= 32'd0;
      BRAM_ADDR   <= 32'd0;
      BRAM_WRDATA <= 32'd0;
      BRAM_WE     <= 4'h0;
      done        <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      row         <= row_nx;
      acc         <= acc_nx;
      BRAM_ADDR   <= addr_nx;
      BRAM_WRDATA <= wrdata_nx;
      BRAM_WE     <= we_nx;
      done        <= done_nx;
    end
  end

  // Local vector RAM; contents survive reset
  always_ff @(posedge aclk) begin
    if ((state == LOAD_V) && capture) begin
      vram[ridx] <= BRAM_RDDATA;
    end
  end

endmodule

// File: tb/tb_mv_pe_con.sv
// Bench for mv_pe_con: small instance (VS=4, NR=2, RD=2) checked every cycle
// against a timeline model, plus a default-parameter instance with random data.
module tb_mv_pe_con;

  localparam int VS  = 4;
  localparam int NR  = 2;
  localparam int RD  = 2;
  localparam int P   = VS + RD;
  localparam int LAT = (NR + 1) * P + NR;

  logic        aclk = 1'b0;
  logic        areset, start, start_b;
  logic        done, done_b, bclk, bclk_b;
  logic [31:0] addr, wrdata, rddata, addr_b, wrdata_b, rddata_b;
  logic [3:0]  we, we_b;

  always #5 aclk = ~aclk;

  mv_pe_con #(.VECTOR_SIZE(VS), .L_RAM_SIZE(2), .NUM_ROWS(NR), .RD_LAT(RD)) dut (
    .aclk(aclk), .areset(areset), .start(start), .done(done),
    .BRAM_ADDR(addr), .BRAM_WRDATA(wrdata), .BRAM_WE(we), .BRAM_CLK(bclk),
    .BRAM_RDDATA(rddata)
  );

  mv_pe_con dut_b (
    .aclk(aclk), .areset(areset), .start(start_b), .done(done_b),
    .BRAM_ADDR(addr_b), .BRAM_WRDATA(wrdata_b), .BRAM_WE(we_b), .BRAM_CLK(bclk_b),
    .BRAM_RDDATA(rddata_b)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // BRAM models with RD-cycle read latency
  logic [31:0] mem   [0:15];
  logic [31:0] mem_b [0:511];
  logic [31:0] pa0, pa1, pb0, pb1;

  always @(posedge aclk) begin
    pa0 <= addr;
    pa1 <= pa0;
    pb0 <= addr_b;
    pb1 <= pb0;
    for (int b = 0; b < 4; b++) begin
      if (we[b])   mem[addr[5:2]][8*b +: 8]     <= wrdata[8*b +: 8];
      if (we_b[b]) mem_b[addr_b[10:2]][8*b +: 8] <= wrdata_b[8*b +: 8];
    end
  end
  assign rddata   = mem[pa1[5:2]];
  assign rddata_b = mem_b[pb1[10:2]];

  // Timeline model: phase 0 idle, 1 running (k = cycles since start edge), 2 done
  int phase = 0;
  int k = 0;
  logic [31:0] exp_res [0:3];

  always @(posedge aclk or posedge areset) begin
    if (areset) begin
      phase <= 0;
    end else if (phase != 1 && start) begin
      phase <= 1;
      k <= 0;
    end else if (phase == 1) begin
      if (k + 1 == LAT) phase <= 2;
      k <= k + 1;
    end
  end

  always @(negedge aclk) begin : compare
    int m, r, j;
    if (phase != 1) begin
      check("idle_done", {31'd0, done}, (phase == 2) ? 32'd1 : 32'd0);
      check("idle_addr", addr, 32'd0);
      check("idle_we", {28'd0, we}, 32'd0);
      check("idle_wrdata", wrdata, 32'd0);
    end else begin
      check("run_done", {31'd0, done}, 32'd0);
      if (k < P) begin
        if (k < VS) check("load_addr", addr, 32'(4 * k));
        check("load_we", {28'd0, we}, 32'd0);
        check("load_wrdata", wrdata, 32'd0);
      end else begin
        m = k - P;
        r = m / (P + 1);
        j = m % (P + 1);
        if (j < P) begin
          if (j < VS) check("mac_addr", addr, 32'(4 * (VS * (r + 1) + j)));
          check("mac_we", {28'd0, we}, 32'd0);
          check("mac_wrdata", wrdata, 32'd0);
        end else begin
          check("wr_we", {28'd0, we}, 32'h0000000F);
          check("wr_addr", addr, 32'(4 * (VS * (NR + 1) + r)));
          check("wr_data", wrdata, exp_res[2'(r)]);
        end
      end
    end
  end

  function automatic logic [31:0] relu(input logic [31:0] x);
`ifdef MV_PE_CON_RELU_EN
    return x[31] ? 32'd0 : x;
`else
    return x;
`endif
  endfunction

  // Element i of each packed argument sits at bits [32*i +: 32]
  task automatic load_case(input logic [127:0] v, input logic [127:0] r0, input logic [127:0] r1);
    logic [31:0] a0, a1;
    a0 = 32'd0;
    a1 = 32'd0;
    for (int i = 0; i < VS; i++) begin
      mem[4'(i)]          <= v[32*i +: 32];
      mem[4'(VS + i)]     <= r0[32*i +: 32];
      mem[4'(2 * VS + i)] <= r1[32*i +: 32];
      a0 = a0 + r0[32*i +: 32] * v[32*i +: 32];
      a1 = a1 + r1[32*i +: 32] * v[32*i +: 32];
    end
    mem[12] <= 32'hDEADBEEF;
    mem[13] <= 32'hDEADBEEF;
    exp_res[0] = relu(a0);
    exp_res[1] = relu(a1);
    @(posedge aclk);
    #1;
  endtask

  task automatic run_small(input int extra_at, output int n);
    start = 1'b1;
    @(posedge aclk);
    #1;
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      start = (n == extra_at);
      @(posedge aclk);
      #1;
      n++;
    end
    start = 1'b0;
  endtask

  localparam logic [127:0] VEC_A = {32'd4, 32'd3, 32'd2, 32'd1};
  localparam logic [127:0] R0_A  = {32'd1, 32'd1, 32'd1, 32'd1};
  localparam logic [127:0] R1_A  = {32'hFFFFFFFF, 32'd0, 32'd0, 32'hFFFFFFFF};

  logic [31:0] vb [0:63];
  logic [31:0] rb [0:255];

  initial begin
    int n, wcnt;
    logic [31:0] neg5, exp_b;
`ifdef MV_PE_CON_RELU_EN
    neg5 = 32'd0;
`else
    neg5 = 32'hFFFFFFFB;
`endif
    areset = 1'b1;
    start = 1'b0;
    start_b = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_addr", addr, 32'd0);
    check("rst_we", {28'd0, we}, 32'd0);
    check("rst_wrdata", wrdata, 32'd0);
    areset = 1'b0;
    repeat (2) @(posedge aclk);
    #1;

    // Basic run: [1,2,3,4] against [1,1,1,1] and [-1,0,0,-1]
    load_case(VEC_A, R0_A, R1_A);
    check("model_row0", exp_res[0], 32'h0000000A);
    run_small(-1, n);
    check("latency_a", n, 32'd20);
    repeat (2) @(posedge aclk);
    #1;
    check("a_word12", mem[12], 32'h0000000A);
    check("a_word13", mem[13], neg5);

    // Wrap-around of a 32-bit product, started from DONE
    load_case({32'd0, 32'd0, 32'd0, 32'h7FFFFFFF}, {32'd0, 32'd0, 32'd0, 32'd2},
              {32'd7, 32'd5, 32'hFFFFFFFE, 32'd3});
    run_small(-1, n);
    check("latency_b", n, 32'd20);
    repeat (2) @(posedge aclk);
    #1;
`ifdef MV_PE_CON_RELU_EN
    check("wrap_word12", mem[12], 32'h00000000);
`else
    check("wrap_word12", mem[12], 32'hFFFFFFFE);
`endif
    check("wrap_word13", mem[13], 32'h7FFFFFFD);

    // Extra start pulses during MAC and LOAD_V are ignored
    load_case(VEC_A, R0_A, R1_A);
    run_small(8, n);
    check("latency_mac_start", n, 32'd20);
    repeat (2) @(posedge aclk);
    #1;
    check("mac_start_word12", mem[12], 32'h0000000A);
    check("mac_start_word13", mem[13], neg5);
    load_case(VEC_A, R0_A, R1_A);
    run_small(2, n);
    check("latency_load_start", n, 32'd20);
    repeat (2) @(posedge aclk);
    #1;
    check("load_start_word13", mem[13], neg5);

    // Reset during MAC of row 1 aborts before the second write
    load_case(VEC_A, R0_A, R1_A);
    start = 1'b1;
    @(posedge aclk);
    #1;
    start = 1'b0;
    repeat (14) @(posedge aclk);
    #2;
    areset = 1'b1;
    #1;
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_addr", addr, 32'd0);
    check("abort_we", {28'd0, we}, 32'd0);
    repeat (2) @(posedge aclk);
    #1;
    check("abort_word12", mem[12], 32'h0000000A);
    check("abort_word13", mem[13], 32'hDEADBEEF);
    areset = 1'b0;
    @(posedge aclk);
    #1;
    load_case(VEC_A, R0_A, R1_A);
    run_small(-1, n);
    check("latency_after_abort", n, 32'd20);
    repeat (2) @(posedge aclk);
    #1;
    check("after_abort_word12", mem[12], 32'h0000000A);
    check("after_abort_word13", mem[13], neg5);

    // Default-parameter instance with random data
    for (int i = 0; i < 64; i++) begin
      vb[6'(i)] = $urandom();
      mem_b[9'(i)] <= vb[6'(i)];
    end
    for (int i = 0; i < 256; i++) begin
      rb[8'(i)] = $urandom();
      mem_b[9'(64 + i)] <= rb[8'(i)];
    end
    for (int i = 320; i < 324; i++) mem_b[9'(i)] <= 32'hDEADBEEF;
    @(posedge aclk);
    #1;
    start_b = 1'b1;
    @(posedge aclk);
    #1;
    start_b = 1'b0;
    n = 0;
    wcnt = 0;
    while (done_b !== 1'b1 && n < 1000) begin
      @(posedge aclk);
      #1;
      n++;
      if (we_b == 4'hF) wcnt++;
    end
    check("latency_default", n, 32'd334);
    check("we_cycles_default", wcnt, 32'd4);
    repeat (2) @(posedge aclk);
    #1;
    for (int r = 0; r < 4; r++) begin
      exp_b = 32'd0;
      for (int i = 0; i < 64; i++) exp_b = exp_b + rb[8'(64 * r + i)] * vb[6'(i)];
      check("default_result", mem_b[9'(320 + r)], relu(exp_b));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
